uart_cmd_ctrl: RTL and testbench

Frame parser and register-write sequencer that sits directly behind the serial receiver. It consumes received bytes and the end-of-packet strobe, and validates framed write commands (sync, address, length, payload, checksum). Only after the checksum passes does it replay the payload as a burst of single-cycle register writes into the design's configuration register file. It is the only path by which the host configures the board over RS-232.

---
 rtl/uart_cmd_pkg.sv | 29 ++
 rtl/uart_cmd_buf.sv | 37 +++
 rtl/uart_cmd_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_cmd_pkg : shared types and constants for the UART command path.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_COMMIT = 3'd5
    } uart_cmd_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CHK   = 2'b01;
    localparam logic [1:0] ERR_LEN   = 2'b10;
    localparam logic [1:0] ERR_TRUNC = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_cmd_buf : payload staging array, one write port, async read.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module uart_cmd_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0] r_mem [0:DEPTH-1];
    logic       w_wr_in_range;
    logic       w_rd_in_range;

    assign w_wr_in_range = ({1'b0, i_waddr} < c_depth);
    assign w_rd_in_range = ({1'b0, i_raddr} < c_depth);

    // Contents are don't-care after an aborted frame, so no reset is needed.
    always_ff @(posedge clk) begin
        if (i_we && w_wr_in_range) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_in_range ? r_mem[i_raddr] : 8'h00;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_cmd_ctrl : validates framed write commands and replays them as   |
// | register writes once the checksum passes.            Rev 1.0          |
// +-----------------------------------------------------------------------+
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_endofpacket,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wr_data,
    output logic              busy,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt
);

    localparam int         c_buf_aw  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    uart_cmd_state_t   r_state, w_state_nx;
    logic [ADDR_W-1:0] r_base, w_base_nx;
    logic [7:0]        r_len, w_len_nx;
    logic [7:0]        r_idx, w_idx_nx;
    logic [7:0]        r_sum, w_sum_nx;
    logic              r_wr_en, w_wr_en_nx;
    logic [ADDR_W-1:0] r_reg_addr, w_reg_addr_nx;
    logic [7:0]        r_wr_data, w_wr_data_nx;
    logic              r_busy;
    logic              r_frame_ok, w_frame_ok_nx;
    logic              r_frame_err;
    logic [1:0]        r_err_code, w_err_code_nx;
    logic [7:0]        r_frame_cnt, w_frame_cnt_nx;
    logic [7:0]        r_err_cnt, w_err_cnt_nx;

    logic              w_fail;
    logic [1:0]        w_fail_code;
    logic              w_buf_we;
    logic [7:0]        w_buf_rdata;
    logic [7:0]        w_rd_idx;
    logic [7:0]        w_sum_chk;
    logic              w_trunc;

    // COMMIT walks the buffer; entering COMMIT from CHK needs entry 0.
    assign w_rd_idx  = (r_state == ST_COMMIT) ? r_idx : 8'd0;
    assign w_sum_chk = r_sum + rx_data;
    assign w_trunc   = rx_endofpacket && !rx_ready;

    uart_cmd_buf #(
        .DEPTH (MAX_LEN),
        .AW    (c_buf_aw)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_idx[c_buf_aw-1:0]),
        .i_wdata (rx_data),
        .i_raddr (w_rd_idx[c_buf_aw-1:0]),
        .o_rdata (w_buf_rdata)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_base_nx      = r_base;
        w_len_nx       = r_len;
        w_idx_nx       = r_idx;
        w_sum_nx       = r_sum;
        w_wr_en_nx     = 1'b0;
        w_reg_addr_nx  = r_reg_addr;
        w_wr_data_nx   = r_wr_data;
        w_frame_ok_nx  = 1'b0;
        w_err_code_nx  = r_err_code;
        w_frame_cnt_nx = r_frame_cnt;
        w_err_cnt_nx   = r_err_cnt;
        w_fail         = 1'b0;
        w_fail_code    = ERR_NONE;
        w_buf_we       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    w_state_nx = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_ready) begin
                    w_base_nx  = ADDR_W'(rx_data);
                    w_sum_nx   = rx_data;
                    w_state_nx = ST_LEN;
                end else if (w_trunc) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TRUNC;
                end
            end
            ST_LEN: begin
                if (rx_ready) begin
                    if ((rx_data == 8'd0) || (rx_data > c_max_len)) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_LEN;
                    end else begin
                        w_len_nx   = rx_data;
                        w_sum_nx   = r_sum + rx_data;
                        w_idx_nx   = 8'd0;
                        w_state_nx = ST_DATA;
                    end
                end else if (w_trunc) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TRUNC;
                end
            end
            ST_DATA: begin
                if (rx_ready) begin
                    w_buf_we = 1'b1;
                    w_sum_nx = r_sum + rx_data;
                    w_idx_nx = r_idx + 8'd1;
                    if (r_idx == (r_len - 8'd1)) begin
                        w_state_nx = ST_CHK;
                    end
                end else if (w_trunc) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TRUNC;
                end
            end
            ST_CHK: begin
                if (rx_ready) begin
                    if (w_sum_chk == 8'd0) begin
                        // First write issues on the same edge that accepts the checksum.
                        w_state_nx    = ST_COMMIT;
                        w_wr_en_nx    = 1'b1;
                        w_reg_addr_nx = r_base;
                        w_wr_data_nx  = w_buf_rdata;
                        w_frame_ok_nx = (r_len == 8'd1);
                        w_idx_nx      = 8'd1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_CHK;
                    end
                end else if (w_trunc) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TRUNC;
                end
            end
            ST_COMMIT: begin
                if (r_idx == r_len) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_wr_en_nx    = 1'b1;
                    w_reg_addr_nx = r_base + ADDR_W'(r_idx);
                    w_wr_data_nx  = w_buf_rdata;
                    w_frame_ok_nx = (r_idx == (r_len - 8'd1));
                    w_idx_nx      = r_idx + 8'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_fail) begin
            w_state_nx    = ST_IDLE;
            w_err_code_nx = w_fail_code;
            w_err_cnt_nx  = sat_inc8(r_err_cnt);
        end
        if (w_frame_ok_nx) begin
            w_frame_cnt_nx = sat_inc8(r_frame_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_len       <= 8'd0;
            r_idx       <= 8'd0;
            r_sum       <= 8'd0;
            r_wr_en     <= 1'b0;
            r_reg_addr  <= '0;
            r_wr_data   <= 8'd0;
            r_busy      <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_frame_cnt <= 8'd0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_state     <= w_state_nx;
            r_base      <= w_base_nx;
            r_len       <= w_len_nx;
            r_idx       <= w_idx_nx;
            r_sum       <= w_sum_nx;
            r_wr_en     <= w_wr_en_nx;
            r_reg_addr  <= w_reg_addr_nx;
            r_wr_data   <= w_wr_data_nx;
            r_busy      <= (w_state_nx != ST_IDLE);
            r_frame_ok  <= w_frame_ok_nx;
            r_frame_err <= w_fail;
            r_err_code  <= w_err_code_nx;
            r_frame_cnt <= w_frame_cnt_nx;
            r_err_cnt   <= w_err_cnt_nx;
        end
    end

    assign reg_wr_en   = r_wr_en;
    assign reg_addr    = r_reg_addr;
    assign reg_wr_data = r_wr_data;
    assign busy        = r_busy;
    assign frame_ok    = r_frame_ok;
    assign frame_err   = r_frame_err;
    assign err_code    = r_err_code;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_cmd_ctrl : self-checking bench for uart_cmd_ctrl.  Rev 1.0    |
// +-----------------------------------------------------------------------+
module tb_uart_cmd_ctrl;

    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_endofpacket = 1'b0;
    logic       reg_wr_en;
    logic [7:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    uart_cmd_ctrl #(
        .ADDR_W    (8),
        .MAX_LEN   (MAXL),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .rx_endofpacket (rx_endofpacket),
        .reg_wr_en      (reg_wr_en),
        .reg_addr       (reg_addr),
        .reg_wr_data    (reg_wr_data),
        .busy           (busy),
        .frame_ok       (frame_ok),
        .frame_err      (frame_err),
        .err_code       (err_code),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    wr_t got_wr[$];
    wr_t exp_wr[$];
    int  n_ok = 0;
    int  n_err = 0;
    int  ok_cyc = 0;
    int  err_cyc = 0;
    int  busy_fall_cyc = 0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) got_wr.push_back('{reg_addr, reg_wr_data, cyc});
        if (frame_ok === 1'b1) begin n_ok++; ok_cyc = cyc; end
        if (frame_err === 1'b1) begin n_err++; err_cyc = cyc; end
        if (busy_q && (busy === 1'b0)) busy_fall_cyc = cyc;
        busy_q = (busy === 1'b1);
    end

    // Reference model state: counters saturate, err_code holds the last cause.
    int         mf = 0;
    int         me = 0;
    logic [1:0] mcode = 2'b00;
    int         d_ok = 0;
    int         d_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_eop();
        rx_endofpacket = 1'b1;
        last_cyc = cyc;
        @(negedge clk);
        rx_endofpacket = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((busy !== 1'b0) && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("busy_timeout", 32'd1, 32'd0);
        idle(2);
    endtask

    task automatic model(input logic [7:0] q[$], input bit eop,
                         output bit ok, output bit err, output logic [1:0] code);
        int p;
        int len;
        int sum;
        logic [7:0] base;
        exp_wr.delete();
        ok = 1'b0; err = 1'b0; code = 2'b00;
        p = 0;
        while (p < q.size() && q[p] != 8'hA5) p++;
        if (p >= q.size()) return;
        if (q.size() - p < 3) begin err = eop; code = 2'b11; return; end
        base = q[p+1];
        len  = int'(q[p+2]);
        if (len == 0 || len > MAXL) begin err = 1'b1; code = 2'b10; return; end
        if (q.size() - p < len + 4) begin err = eop; code = 2'b11; return; end
        sum = 0;
        for (int i = 1; i <= len + 3; i++) sum += int'(q[p+i]);
        if (sum % 256 != 0) begin err = 1'b1; code = 2'b01; return; end
        ok = 1'b1;
        for (int i = 0; i < len; i++) exp_wr.push_back('{base + 8'(i), q[p+3+i], 0});
    endtask

    task automatic run_frame(input logic [7:0] q[$], input bit eop, input bit gaps);
        int ok0, err0;
        bit ok, err;
        logic [1:0] code;
        ok0 = n_ok;
        err0 = n_err;
        got_wr.delete();
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gaps) idle($urandom_range(0, 2));
        end
        if (eop) send_eop();
        wait_done();
        model(q, eop, ok, err, code);
        if (ok) mf = (mf < 255) ? mf + 1 : 255;
        if (err) begin me = (me < 255) ? me + 1 : 255; mcode = code; end
        d_ok = n_ok - ok0;
        d_err = n_err - err0;
        check("wr_count", got_wr.size(), exp_wr.size());
        if (got_wr.size() == exp_wr.size()) begin
            foreach (exp_wr[i]) begin
                check("wr_addr_data", {got_wr[i].a, got_wr[i].d}, {exp_wr[i].a, exp_wr[i].d});
                if (i > 0) check("wr_consecutive", got_wr[i].c - got_wr[i-1].c, 1);
            end
        end
        check("ok_pulses", d_ok, {31'd0, ok});
        check("err_pulses", d_err, {31'd0, err});
        check("err_code", err_code, mcode);
        check("frame_cnt", frame_cnt, mf);
        check("err_cnt", err_cnt, me);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        mf = 0; me = 0; mcode = 2'b00;
    endtask

    task automatic random_frames(input int nf);
        logic [7:0] q[$];
        logic [7:0] s, c, g, addr, len, d;
        int k, cut;
        bit eop;
        for (int f = 0; f < nf; f++) begin
            q.delete();
            k = $urandom_range(0, 4);
            eop = 1'b0;
            if (k == 4) begin
                repeat ($urandom_range(1, 3)) begin
                    g = 8'($urandom_range(0, 255));
                    if (g == 8'hA5) g = 8'h00;
                    q.push_back(g);
                end
            end
            addr = 8'($urandom);
            if (k == 2) begin
                len = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(MAXL + 1, 255));
                q.push_back(8'hA5); q.push_back(addr); q.push_back(len);
            end else begin
                len = 8'($urandom_range(1, MAXL));
                q.push_back(8'hA5); q.push_back(addr); q.push_back(len);
                s = addr + len;
                for (int i = 0; i < int'(len); i++) begin
                    d = 8'($urandom);
                    q.push_back(d);
                    s = s + d;
                end
                c = 8'd0 - s;
                if (k == 1) c = c ^ 8'($urandom_range(1, 255));
                q.push_back(c);
                if (k == 3) begin
                    cut = $urandom_range(1, q.size() - 1);
                    while (q.size() > cut) void'(q.pop_back());
                    eop = 1'b1;
                end
            end
            run_frame(q, eop, 1'b1);
        end
    endtask

    typedef struct {
        int          n;
        logic [71:0] b;
        bit          eop;
        bit          exp_ok;
        bit          exp_err;
        logic [1:0]  exp_code;
        int          exp_nwr;
        logic [7:0]  exp_a0;
    } vec_t;

    vec_t vec[7];

    initial begin
        logic [7:0] q[$];
        int n0, ok0, err0;
        vec[0] = '{7, {72'hA5_10_03_11_22_33_87_00_00}, 1'b0, 1'b1, 1'b0, 2'b00, 3, 8'h10};
        vec[1] = '{7, {72'hA5_10_03_11_22_33_88_00_00}, 1'b0, 1'b0, 1'b1, 2'b01, 0, 8'h00};
        vec[2] = '{3, {72'hA5_10_00_00_00_00_00_00_00}, 1'b0, 1'b0, 1'b1, 2'b10, 0, 8'h00};
        vec[3] = '{3, {72'hA5_10_11_00_00_00_00_00_00}, 1'b0, 1'b0, 1'b1, 2'b10, 0, 8'h00};
        vec[4] = '{4, {72'hA5_10_03_11_00_00_00_00_00}, 1'b1, 1'b0, 1'b1, 2'b11, 0, 8'h00};
        vec[5] = '{9, {72'h00_FF_A5_10_03_11_22_33_87}, 1'b0, 1'b1, 1'b0, 2'b11, 3, 8'h10};
        vec[6] = '{7, {72'hA5_FE_03_01_02_03_F9_00_00}, 1'b0, 1'b1, 1'b0, 2'b11, 3, 8'hFE};

        @(negedge clk);
        idle(2);
        check("rst_wr_en", reg_wr_en, 0);
        check("rst_addr_data", {reg_addr, reg_wr_data}, 0);
        check("rst_busy_ok_err", {busy, frame_ok, frame_err}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_counters", {frame_cnt, err_cnt}, 0);
        rst_n = 1'b1;
        idle(1);

        // Table-driven directed frames
        for (int v = 0; v < 7; v++) begin
            q.delete();
            for (int i = 0; i < vec[v].n; i++) q.push_back(vec[v].b[71 - 8*i -: 8]);
            run_frame(q, vec[v].eop, 1'b0);
            check($sformatf("vec%0d_ok", v), d_ok, {31'd0, vec[v].exp_ok});
            check($sformatf("vec%0d_err", v), d_err, {31'd0, vec[v].exp_err});
            check($sformatf("vec%0d_code", v), err_code, vec[v].exp_code);
            check($sformatf("vec%0d_nwr", v), got_wr.size(), vec[v].exp_nwr);
            if (vec[v].exp_nwr > 0 && got_wr.size() > 0)
                check($sformatf("vec%0d_a0", v), got_wr[0].a, vec[v].exp_a0);
        end
        check("tbl_frame_cnt", frame_cnt, 3);
        check("tbl_err_cnt", err_cnt, 4);

        // Commit timing relative to the checksum byte
        got_wr.delete();
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hD2);
        n0 = last_cyc;
        wait_done();
        check("tim_nwr", got_wr.size(), 4);
        if (got_wr.size() == 4) begin
            check("tim_first_wr", got_wr[0].c, n0 + 1);
            check("tim_last_wr", got_wr[3].c, n0 + 4);
            check("tim_last_addr", got_wr[3].a, 8'h23);
        end
        check("tim_frame_ok", ok_cyc, n0 + 4);
        check("tim_busy_fall", busy_fall_cyc, n0 + 5);

        // Error pulse timing: bad length, then truncation
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00);
        n0 = last_cyc;
        idle(2);
        check("tim_len_err", err_cyc, n0 + 1);
        send_byte(8'hA5); send_byte(8'h20);
        send_eop();
        n0 = last_cyc;
        idle(2);
        check("tim_trunc_err", err_cyc, n0 + 1);
        check("trunc_code", err_code, 2'b11);

        // rx_ready together with rx_endofpacket inside DATA
        ok0 = n_ok; err0 = n_err; got_wr.delete();
        send_byte(8'hA5); send_byte(8'h30); send_byte(8'h02);
        rx_endofpacket = 1'b1;
        send_byte(8'h55);
        rx_endofpacket = 1'b0;
        send_byte(8'h66); send_byte(8'h13);
        wait_done();
        check("eop_data_ok", n_ok - ok0, 1);
        check("eop_data_err", n_err - err0, 0);
        check("eop_data_nwr", got_wr.size(), 2);

        // Back-to-back: SYNC in the first cycle back in IDLE
        ok0 = n_ok; got_wr.delete();
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h59);
        idle(2);
        check("b2b_busy_low", busy, 0);
        send_byte(8'hA5); send_byte(8'h50); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'h38);
        wait_done();
        check("b2b_ok", n_ok - ok0, 2);
        check("b2b_nwr", got_wr.size(), 3);

        // Reset asserted in the middle of COMMIT
        got_wr.delete();
        send_byte(8'hA5); send_byte(8'h60); send_byte(8'h08);
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        send_byte(8'h7C);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        check("rstc_wr_en", reg_wr_en, 0);
        check("rstc_busy", busy, 0);
        check("rstc_outs", {reg_addr, reg_wr_data, frame_cnt, err_cnt, err_code}, 0);
        idle(3);
        check("rstc_nwr", got_wr.size(), 4);
        rst_n = 1'b1;
        idle(1);
        mf = 0; me = 0; mcode = 2'b00;

        // Randomised frames against the reference model
        random_frames(40);

        // Error counter saturation
        do_reset();
        err0 = n_err;
        for (int i = 0; i < 257; i++) begin
            send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        end
        idle(2);
        check("sat_err_pulses", n_err - err0, 257);
        check("sat_err_cnt", err_cnt, 255);
        check("sat_frame_cnt", frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
